// File: rtl/rs232_rxd.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rxd
// Description : RS-232/UART receiver clocked by a 16x-oversampled bit clock.
//               Frame: idle high, 1 start bit, DATA_BITS data bits LSB first,
//               1 stop bit. Each good word is presented on DataOut with a
//               one-cycle DataValid strobe; a low stop bit gives a one-cycle
//               FramingError strobe instead.
//               Optional macro RS232_RXD_PARITY_EN inserts a parity bit
//               between data and stop and adds the ParityError output.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_rxd #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clock16x,
    input  logic                 Reset,
    input  logic                 Rxd,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataValid,
    output logic                 FramingError,
`ifdef RS232_RXD_PARITY_EN
    output logic                 ParityError,
`endif
    output logic                 Busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS) + 1;

    // Mid-bit of the start bit, and the end of every full bit period
    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    // Reject configurations the counters cannot represent
    if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 8 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("rs232_rxd: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RS232_RXD_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_data_out;
    logic                  r_data_valid;
    logic                  r_framing_err;

`ifdef RS232_RXD_PARITY_EN
    localparam logic c_PARITY_ODD = (PARITY_ODD != 0);

    logic r_par_bit;
    logic r_parity_err;
    logic w_parity_bad;

    // Even sense: data plus parity must XOR to 0; odd sense: to 1
    assign w_parity_bad = ((^r_shift) ^ r_par_bit) != c_PARITY_ODD;
    assign ParityError  = r_parity_err;
`endif

    // Two-flop synchronizer; resets high so reset release never looks like a start bit
    always_ff @(posedge Clock16x or negedge Reset) begin
        if (!Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= Rxd;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame state machine with registered word and single-cycle status strobes
    always_ff @(posedge Clock16x or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
`ifdef RS232_RXD_PARITY_EN
            r_par_bit     <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
`ifdef RS232_RXD_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_tick  <= '0;
                    end
                end
                S_START: begin
                    if (r_tick == c_TICK_MID) begin
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_tick    <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            // Start bit did not survive to its centre: a glitch
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_DATA: begin
                    // Tick wraps to 0 on its own, realigning on the next bit centre
                    r_tick <= r_tick + 1'b1;
                    if (r_tick == c_TICK_LAST) begin
                        r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_BIT_LAST) begin
`ifdef RS232_RXD_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef RS232_RXD_PARITY_EN
                S_PARITY: begin
                    r_tick <= r_tick + 1'b1;
                    if (r_tick == c_TICK_LAST) begin
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    r_tick <= r_tick + 1'b1;
                    if (r_tick == c_TICK_LAST) begin
                        // Leave at mid stop bit so a start bit right behind it is caught
                        r_state <= S_IDLE;
                        if (r_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_framing_err <= 1'b1;
                        end
`ifdef RS232_RXD_PARITY_EN
                        r_parity_err <= w_parity_bad;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= '0;
                end
            endcase
        end
    end

    assign DataOut      = r_data_out;
    assign DataValid    = r_data_valid;
    assign FramingError = r_framing_err;
    assign Busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/rs232_rxd.md
Name: rs232_rxd

Overview:
- UART/RS-232 receiver: the receive-side counterpart of the RS232Txd transmitter.
- Clocked by the same 16x-oversampled bit clock as the transmitter.
- Deserializes frames on the serial input:
  - idle high, 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high).
- Presents each received word on a parallel bus with a one-cycle valid strobe.
- Sits opposite RS232Txd for loopback and link tests.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, clocks per bit period (power of 2, >=8).
- PARITY_ODD, 0, parity sense when RS232_RXD_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- Clock16x  in  1  oversampling clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Rxd  in  1  serial input; asynchronous to Clock16x; idle high.
- DataOut  out  DATA_BITS  last received word; holds until the next good frame.
- DataValid  out  1  one-cycle pulse when DataOut updates.
- FramingError  out  1  one-cycle pulse when the stop bit is sampled low.
- Busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low (Reset = 0 resets).
- Reset values:
  - DataOut = 0; DataValid = 0; FramingError = 0; Busy = 0.
  - State = IDLE; counters = 0.
  - Synchronizer flops = 1, so no false start is detected after reset.
- Input sync: Rxd passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- Counters:
  - tick counter, log2(OVERSAMPLE) bits.
  - bit counter, log2(DATA_BITS)+1 bits.
- State machine:
  - IDLE: when rx_s = 0, go to START with tick = 0.
  - START: tick increments each clock.
    - At tick = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - If rx_s = 0: go to DATA, tick = 0, bit = 0.
    - If rx_s = 1: treat as a glitch and return to IDLE with no output pulses.
  - DATA: tick increments and wraps.
    - At tick = OVERSAMPLE-1, shift rx_s in at the MSB of the shift register (right shift, so the first bit received ends up as the LSB) and increment bit.
    - After DATA_BITS samples, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: at tick = OVERSAMPLE-1, sample rx_s.
    - rx_s = 1: DataOut <= shift register; DataValid = 1 for one clock.
    - rx_s = 0: FramingError = 1 for one clock; DataOut unchanged; DataValid stays 0.
    - Either way, go to IDLE on the same edge, i.e. at mid stop bit. This allows back-to-back frames with a single stop bit.
- Latency: DataValid rises 2 + OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) clocks after Rxd falls, +/-1 for synchronizer phase. This is 154 clocks for the defaults.
- Boundary cases:
  - A Rxd edge mid-bit during DATA has no effect; only the centre sample counts.
  - Rxd held low continuously (break): every frame ends in FramingError. The next start is detected immediately, because rx_s is still low in IDLE.
  - DataValid and FramingError are never high in the same cycle.
  - Reset asserted mid-frame aborts the frame immediately; no pulse is emitted for the aborted frame.

Optional Feature:
- Macro: RS232_RXD_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; it samples one parity bit at tick = OVERSAMPLE-1.
  - Adds an output port ParityError (1 bit, reset 0).
  - Parity mismatch against PARITY_ODD: at STOP, ParityError pulses for one clock alongside DataValid (valid stop bit) or alongside FramingError (bad stop bit). DataOut still updates if the stop bit is good.
  - Latency grows by OVERSAMPLE clocks.
- Undefined:
  - No PARITY state and no ParityError port.
  - Frame is 8N1 for the defaults.

Test Plan:
- Release Reset; drive 0xAA frame at 16 clocks/bit (start 0; data bits 0,1,0,1,0,1,0,1; stop 1) -> one DataValid pulse ~154 clocks after the start edge; DataOut = 0xAA; FramingError stays 0.
- Rxd low for 4 clocks, then high -> Busy pulses briefly; returns to IDLE; no DataValid, no FramingError.
- Frame 0x3C with stop bit driven 0 -> FramingError pulses once; DataValid stays 0; DataOut keeps its previous value.
- Back-to-back 0x55 then 0x0F with one stop bit each and no idle gap -> two DataValid pulses 160 clocks apart; DataOut = 0x55, then 0x0F.
- Assert Reset during data bit 3 of a frame, release, then send 0x81 -> outputs 0 during reset; the aborted frame gives no pulse; DataOut = 0x81 afterwards.
- With RS232_RXD_PARITY_EN and PARITY_ODD = 0:
  - 0xA5 with parity bit 0 -> DataValid, ParityError = 0.
  - 0xA5 with parity bit 1 -> DataValid and ParityError pulse together.
